// File: rtl/key_pkg.sv
// Shared types and constants for the key pulse conditioner: channel states,
// key indices and default timing parameters.
package key_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      HOLD = 2'd2
   } chan_state_e;

   localparam int KEY_RECD = 0;
   localparam int KEY_PLAY = 1;
   localparam int KEY_STOP = 2;

   localparam int N_KEYS_DEF          = 3;
   localparam int DEBOUNCE_CYCLES_DEF = 1000000;
   localparam int BCLK_TIMEOUT_DEF    = 4096;

   // Counter width able to hold n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/key_pulse_conditioner_if.sv
// Key/BCLK bundle between the push-button front end and its consumer.
interface key_pulse_conditioner_if #(
   parameter int N_KEYS = 3
);
   logic [N_KEYS-1:0] key_n;
   logic              aud_bclk;
   logic [N_KEYS-1:0] key;
   logic [N_KEYS-1:0] key_level;
   logic              timeout;

   modport master (
      output key_n,
      output aud_bclk,
      input  key,
      input  key_level,
      input  timeout
   );

   modport slave (
      input  key_n,
      input  aud_bclk,
      output key,
      output key_level,
      output timeout
   );
endinterface

// File: rtl/key_debounce.sv
// One push-button channel: 2-FF synchroniser, hold-time debounce counter and
// a one-cycle press strobe on the accepted released->pressed transition.
module key_debounce
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic i_50M_clk,
   input  logic i_rst_n,
   input  logic i_key_n,
   output logic o_stable,
   output logic o_press_evt
);
   localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          key_meta_r;
   logic          key_sync_r;
   logic          stable_r;
   logic          press_evt_r;
   logic [CW-1:0] cnt_r;

   // Bring the inverted raw key into the clock domain.
   always_ff @(posedge i_50M_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         key_meta_r <= 1'b0;
         key_sync_r <= 1'b0;
      end else begin
         key_meta_r <= ~i_key_n;
         key_sync_r <= key_meta_r;
      end
   end

   // Accept a new level only after it differs for DEBOUNCE_CYCLES consecutive cycles.
   always_ff @(posedge i_50M_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stable_r    <= 1'b0;
         press_evt_r <= 1'b0;
         cnt_r       <= {CW{1'b0}};
      end else if (key_sync_r != stable_r) begin
         if (cnt_r == CNT_LAST) begin
            stable_r    <= key_sync_r;
            press_evt_r <= key_sync_r;
            cnt_r       <= {CW{1'b0}};
         end else begin
            stable_r    <= stable_r;
            press_evt_r <= 1'b0;
            cnt_r       <= cnt_r + CW'(1);
         end
      end else begin
         stable_r    <= stable_r;
         press_evt_r <= 1'b0;
         cnt_r       <= {CW{1'b0}};
      end
   end

   assign o_stable    = stable_r;
   assign o_press_evt = press_evt_r;

endmodule

// File: rtl/key_pulse_conditioner.sv
// Debounces the push-buttons and turns each press into an o_key pulse aligned
// to oversampled BCLK rising edges so a BCLK-domain FSM sees it exactly once.
module key_pulse_conditioner
   import key_pkg::*;
#(
   parameter int N_KEYS          = N_KEYS_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int BCLK_TIMEOUT    = BCLK_TIMEOUT_DEF
) (
   input  logic                     i_50M_clk,
   input  logic                     i_rst_n,
   key_pulse_conditioner_if.slave   bus
);
   localparam int            TW         = cnt_width(BCLK_TIMEOUT);
   localparam logic [TW-1:0] TIMER_LAST = TW'(BCLK_TIMEOUT - 1);

   logic              bclk_meta_r;
   logic              bclk_sync_r;
   logic              bclk_hist_r;
   logic              bclk_rise_s;
   logic [N_KEYS-1:0] stable_s;
   logic [N_KEYS-1:0] press_evt_s;
   logic [N_KEYS-1:0] abort_s;
   logic [N_KEYS-1:0] key_vec_s;
   logic [N_KEYS-1:0] key_level_r;
   logic              timeout_r;

   // BCLK is only ever sampled as data; the history bit yields a one-cycle rise strobe.
   always_ff @(posedge i_50M_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         bclk_meta_r <= 1'b0;
         bclk_sync_r <= 1'b0;
         bclk_hist_r <= 1'b0;
      end else begin
         bclk_meta_r <= bus.aud_bclk;
         bclk_sync_r <= bclk_meta_r;
         bclk_hist_r <= bclk_sync_r;
      end
   end

   assign bclk_rise_s = bclk_sync_r & ~bclk_hist_r;

   for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
      chan_state_e   state_r;
      logic [TW-1:0] timer_r;
      logic          key_r;

      key_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
         .i_50M_clk   (i_50M_clk),
         .i_rst_n     (i_rst_n),
         .i_key_n     (bus.key_n[g]),
         .o_stable    (stable_s[g]),
         .o_press_evt (press_evt_s[g])
      );

      // Presses arriving while a pulse is in flight are dropped rather than queued.
      always_ff @(posedge i_50M_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            state_r <= IDLE;
            timer_r <= {TW{1'b0}};
            key_r   <= 1'b0;
         end else begin
            case (state_r)
               IDLE: begin
                  timer_r <= {TW{1'b0}};
                  key_r   <= 1'b0;
                  if (press_evt_s[g]) state_r <= ARM;
                  else                state_r <= IDLE;
               end
               ARM: begin
                  if (bclk_rise_s) begin
                     state_r <= HOLD;
                     timer_r <= {TW{1'b0}};
                     key_r   <= 1'b1;
                  end else if (timer_r == TIMER_LAST) begin
                     state_r <= IDLE;
                     timer_r <= {TW{1'b0}};
                     key_r   <= 1'b0;
                  end else begin
                     state_r <= ARM;
                     timer_r <= timer_r + TW'(1);
                     key_r   <= 1'b0;
                  end
               end
               HOLD: begin
                  if (bclk_rise_s || (timer_r == TIMER_LAST)) begin
                     state_r <= IDLE;
                     timer_r <= {TW{1'b0}};
                     key_r   <= 1'b0;
                  end else begin
                     state_r <= HOLD;
                     timer_r <= timer_r + TW'(1);
                     key_r   <= 1'b1;
                  end
               end
               default: begin
                  state_r <= IDLE;
                  timer_r <= {TW{1'b0}};
                  key_r   <= 1'b0;
               end
            endcase
         end
      end

      assign abort_s[g]   = (state_r != IDLE) && !bclk_rise_s && (timer_r == TIMER_LAST);
      assign key_vec_s[g] = key_r;
   end

   // Registered debounced levels and the merged abort flag.
   always_ff @(posedge i_50M_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         key_level_r <= {N_KEYS{1'b0}};
         timeout_r   <= 1'b0;
      end else begin
         key_level_r <= stable_s;
         timeout_r   <= |abort_s;
      end
   end

   assign bus.key       = key_vec_s;
   assign bus.key_level = key_level_r;
   assign bus.timeout   = timeout_r;

endmodule

// File: tb/tb_key_pulse_conditioner.sv
// Directed bench for key_pulse_conditioner: glitch-length table plus
// hand-written sequences for pulse shaping, bounce, timeout and reset.
module tb_key_pulse_conditioner;
   import key_pkg::*;

   localparam int NK  = 3;
   localparam int DEB = 8;
   localparam int TO  = 64;

   logic clk     = 1'b0;
   logic rst_n   = 1'b0;
   logic bclk_en = 1'b0;

   key_pulse_conditioner_if #(.N_KEYS(NK)) bus();

   key_pulse_conditioner #(
      .N_KEYS          (NK),
      .DEBOUNCE_CYCLES (DEB),
      .BCLK_TIMEOUT    (TO)
   ) dut (
      .i_50M_clk (clk),
      .i_rst_n   (rst_n),
      .bus       (bus)
   );

   always #10 clk = ~clk;

   // BCLK: 320 ns period, phase offset so its edges never coincide with clk edges.
   initial begin
      bus.aud_bclk = 1'b0;
      #3;
      forever begin
         #160;
         bus.aud_bclk = bclk_en ? ~bus.aud_bclk : 1'b0;
      end
   end

   int pulses[NK];
   int hi_cyc[NK];
   int lvl_rises[NK];
   int bclk_hits[NK];
   int to_cyc;
   logic [NK-1:0] prev_key = '0;
   logic [NK-1:0] prev_lvl = '0;

   always @(negedge clk) begin
      for (int i = 0; i < NK; i++) begin
         if (bus.key[i] === 1'b1 && prev_key[i] !== 1'b1) pulses[i] <= pulses[i] + 1;
         if (bus.key[i] === 1'b1) hi_cyc[i] <= hi_cyc[i] + 1;
         if (bus.key_level[i] === 1'b1 && prev_lvl[i] !== 1'b1) lvl_rises[i] <= lvl_rises[i] + 1;
      end
      if (bus.timeout === 1'b1) to_cyc <= to_cyc + 1;
      prev_key <= bus.key;
      prev_lvl <= bus.key_level;
   end

   // BCLK-domain view: how many BCLK rising edges saw each o_key bit high.
   always @(posedge bus.aud_bclk) begin
      for (int i = 0; i < NK; i++)
         if (bus.key[i] === 1'b1) bclk_hits[i] <= bclk_hits[i] + 1;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   int sp[NK], sh[NK], sl[NK], sb[NK];
   int st;

   task automatic snap();
      for (int i = 0; i < NK; i++) begin
         sp[i] = pulses[i];
         sh[i] = hi_cyc[i];
         sl[i] = lvl_rises[i];
         sb[i] = bclk_hits[i];
      end
      st = to_cyc;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_key_rise(input int idx, input int bound, output bit found);
      found = 1'b0;
      for (int c = 0; c < bound && !found; c++) begin
         @(negedge clk);
         if (bus.key[idx] === 1'b1) found = 1'b1;
      end
   endtask

   typedef struct {
      int idx;
      int low_len;
      int exp_rise;
      int exp_pulse;
   } vec_t;

   vec_t vecs[5];
   bit   found;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{1,  1, 0, 0};
      vecs[1] = '{1,  3, 0, 0};
      vecs[2] = '{1,  7, 0, 0};
      vecs[3] = '{1,  8, 1, 1};
      vecs[4] = '{2, 30, 1, 1};

      bus.key_n = '1;
      rst_n     = 1'b0;
      cycles(3);
      check("reset_key",     int'(bus.key),       0);
      check("reset_level",   int'(bus.key_level), 0);
      check("reset_timeout", int'(bus.timeout),   0);
      rst_n   = 1'b1;
      bclk_en = 1'b1;
      cycles(20);

      // Low-pulse length against the debounce threshold.
      for (int v = 0; v < 5; v++) begin
         snap();
         bus.key_n[vecs[v].idx] = 1'b0;
         cycles(vecs[v].low_len);
         bus.key_n[vecs[v].idx] = 1'b1;
         cycles(150);
         check($sformatf("vec%0d_level_rises", v), lvl_rises[vecs[v].idx] - sl[vecs[v].idx], vecs[v].exp_rise);
         check($sformatf("vec%0d_pulses", v),      pulses[vecs[v].idx]    - sp[vecs[v].idx], vecs[v].exp_pulse);
         check($sformatf("vec%0d_bclk_hits", v),   bclk_hits[vecs[v].idx] - sb[vecs[v].idx], vecs[v].exp_pulse);
      end

      // Clean press of key 0 held 200 cycles: level latency and a single pulse.
      snap();
      bus.key_n[0] = 1'b0;
      cycles(10);
      check("clean_level_c10", int'(bus.key_level[0]), 0);
      cycles(1);
      check("clean_level_c11", int'(bus.key_level[0]), 1);
      cycles(189);
      check("clean_pulses",    pulses[0] - sp[0],    1);
      check("clean_bclk_hits", bclk_hits[0] - sb[0], 1);
      check("clean_width",     hi_cyc[0] - sh[0],    16);
      bus.key_n[0] = 1'b1;
      cycles(50);

      // Bounce on key 1, then a real press.
      snap();
      for (int i = 0; i < 10; i++) begin
         bus.key_n[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
         cycles(3);
      end
      bus.key_n[1] = 1'b1;
      cycles(60);
      check("bounce_level_rises", lvl_rises[1] - sl[1], 0);
      check("bounce_pulses",      pulses[1] - sp[1],    0);
      bus.key_n[1] = 1'b0;
      cycles(120);
      check("bounce_hold_pulses", pulses[1] - sp[1],    1);
      check("bounce_hold_hits",   bclk_hits[1] - sb[1], 1);
      bus.key_n[1] = 1'b1;
      cycles(50);

      // Keys 0 and 2 pressed in the same cycle.
      snap();
      bus.key_n = 3'b010;
      cycles(120);
      check("simul_pulses_k0", pulses[0] - sp[0],    1);
      check("simul_pulses_k2", pulses[2] - sp[2],    1);
      check("simul_hits_k0",   bclk_hits[0] - sb[0], 1);
      check("simul_hits_k2",   bclk_hits[2] - sb[2], 1);
      check("simul_width_k0",  hi_cyc[0] - sh[0],    16);
      check("simul_width_k2",  hi_cyc[2] - sh[2],    16);
      bus.key_n = 3'b111;
      cycles(50);

      // BCLK stopped: key 2 arms, times out after 64 cycles in ARM, returns to IDLE.
      bclk_en = 1'b0;
      cycles(30);
      snap();
      bus.key_n[2] = 1'b0;
      cycles(74);
      check("to_before", int'(bus.timeout), 0);
      cycles(1);
      check("to_at",     int'(bus.timeout), 1);
      cycles(1);
      check("to_after",  int'(bus.timeout), 0);
      cycles(70);
      check("to_count",      to_cyc - st,        1);
      check("to_no_pulse",   hi_cyc[2] - sh[2],  0);
      bus.key_n[2] = 1'b1;
      cycles(30);
      bclk_en = 1'b1;
      cycles(100);
      check("to_back_idle",  pulses[2] - sp[2],  0);

      // Reset asserted while key 0 is in HOLD.
      bus.key_n[0] = 1'b0;
      wait_key_rise(0, 100, found);
      check("rst_wait_pulse", int'(found), 1);
      cycles(4);
      #3;
      rst_n = 1'b0;
      #1;
      check("rst_key_drop", int'(bus.key), 0);
      bus.key_n[0] = 1'b1;
      cycles(3);
      rst_n = 1'b1;
      cycles(2);
      check("rst_post_key",     int'(bus.key),       0);
      check("rst_post_level",   int'(bus.key_level), 0);
      check("rst_post_timeout", int'(bus.timeout),   0);

      // Clean press after reset, release for 20 cycles, re-press 40 cycles after the first pulse.
      snap();
      bus.key_n[0] = 1'b0;
      wait_key_rise(0, 100, found);
      check("repress_wait_pulse", int'(found), 1);
      cycles(20);
      check("repress_first_pulses", pulses[0] - sp[0], 1);
      check("repress_first_width",  hi_cyc[0] - sh[0], 16);
      bus.key_n[0] = 1'b1;
      cycles(20);
      check("repress_released_level", int'(bus.key_level[0]), 0);
      check("repress_release_no_pulse", pulses[0] - sp[0], 1);
      bus.key_n[0] = 1'b0;
      cycles(120);
      check("repress_second_pulses", pulses[0] - sp[0], 2);
      bus.key_n[0] = 1'b1;
      cycles(40);

      check("total_timeout_cycles", to_cyc, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
